lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Load/store initiator between the MIPS core's memory stage and the word-wide, byte-addressed, big-endian data RAM (synchronous write, registered read with 1-cycle latency).
- Accepts one byte, halfword or word load/store at a time from the core.
- Aligns and sign/zero-extends load data.
- Turns sub-word stores into read-modify-write word accesses.
- Flags misaligned or out-of-range addresses without touching memory.

Parameters:
MEM_BYTES, 4096, RAM size in bytes; addresses >= MEM_BYTES are errors
ADDR_W, 32, width of core and RAM address buses

Ports:
clk  in  1  single clock; all state changes on its rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core presents a request
req_ready  out  1  block can accept; high only in IDLE with rst_n high
req_op  in  3  operation code (lsu_pkg::lsu_op_t)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified (SB uses [7:0], SH uses [15:0])
resp_valid  out  1  single-cycle pulse: request complete
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  valid with resp_valid: misaligned or out of range
mem_a  out  ADDR_W  RAM word address, {addr[ADDR_W-1:2],2'b00}
mem_we  out  1  RAM write enable
mem_wd  out  32  RAM write data
mem_rd  in  32  RAM read data, valid the cycle after mem_a is presented

Behaviour:
- Reset (async, while rst_n low):
  - state=IDLE.
  - req_ready, resp_valid, resp_err, mem_we = 0.
  - resp_rdata, mem_a, mem_wd = 0.
  - A reset mid-operation abandons the request; no write is issued after reset asserts.
- States: IDLE, RD_ISSUE, RD_CAP, WRITE, RESP.
- Accept: a request is accepted on the edge where req_valid && req_ready. op, addr and wdata are latched. Inputs are ignored at all other times.
- Error check at accept:
  - Error if LH/LHU/SH with addr[0]=1.
  - Error if LW/SW with addr[1:0]!=0.
  - Error if addr >= MEM_BYTES.
  - On error: go to RESP with resp_err=1 and resp_rdata=0. mem_we is never asserted.
- Load (LB, LBU, LH, LHU, LW):
  - Sequence IDLE -> RD_ISSUE -> RD_CAP -> RESP -> IDLE.
  - mem_a is driven in RD_ISSUE and held through RD_CAP.
  - In RD_CAP, mem_rd is extracted, extended and registered into resp_rdata.
  - resp_valid is high in the 3rd cycle after accept.
- Word store (SW):
  - Sequence IDLE -> WRITE -> RESP.
  - In WRITE: mem_we=1, mem_wd=wdata.
  - resp_valid is high in the 2nd cycle after accept.
- Sub-word store (SB, SH):
  - Sequence IDLE -> RD_ISSUE -> RD_CAP -> WRITE -> RESP.
  - In RD_CAP, the selected lane of mem_rd is replaced by the store data and the merged word is registered.
  - In WRITE: mem_we=1, mem_wd=merged word.
  - resp_valid is high in the 4th cycle after accept.
- Byte lanes (big-endian): byte offset k (addr[1:0]) maps to word bits [31-8k -: 8].
  - Halfword offset 0 maps to [31:16]; offset 2 maps to [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- mem_we is high only in WRITE. mem_a is 0 in IDLE. mem_wd is 0 outside WRITE.
- resp_valid lasts exactly one cycle and has no backpressure. RESP always returns to IDLE, so back-to-back requests have a 1-cycle IDLE gap.
- Undefined op codes are treated as an error response.

Decomposition:
- lsu_pkg:
  - lsu_op_t enum: LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7.
  - lsu_state_t enum.
  - Functions is_store(op) and size_of(op).
- Sub-module lsu_lane_align: combinational.
  - Inputs: op, offset, mem word, store data.
  - Outputs: extended load word and merged store word.
  - Instantiated once and unit-testable alone.

Test Plan:
- RAM word 0x100 = 0x8123_45F6. LB at 0x100, 0x101, 0x103 -> resp_rdata 0xFFFF_FF81, 0x0000_0023, 0xFFFF_FFF6. LBU at 0x100 -> 0x0000_0081. Each response 3 cycles after accept.
- Same word: LH 0x102 -> 0x0000_45F6; LH 0x100 -> 0xFFFF_8123; LHU 0x100 -> 0x0000_8123; LW 0x100 -> 0x8123_45F6.
- SB 0x101 wdata 0xAA: mem_we high in exactly one cycle with mem_wd 0x81AA_45F6; response 4 cycles after accept. Then SH 0x102 wdata 0xBEEF -> word 0x81AA_BEEF.
- SW 0x200 wdata 0xDEAD_BEEF -> mem_we one cycle, response 2 cycles after accept. LW 0x200 -> 0xDEAD_BEEF.
- LW 0x102, SH 0x103, LB 0x1000 (MEM_BYTES=4096) -> resp_err=1, resp_rdata=0, response 1 cycle after accept, mem_we never high, RAM unchanged.
- SB issued, rst_n pulled low during RD_CAP -> mem_we stays 0, target word unchanged. After release: req_ready=1, resp_valid=0, and the next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory port: op codes, FSM states
// and access-size decoding.
package lsu_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LBU = 3'd1,
        LH  = 3'd2,
        LHU = 3'd3,
        LW  = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } lsu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_CAP,
        ST_WRITE,
        ST_RESP
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    localparam int unsigned WORD_BYTES = 4;

    function automatic logic is_store(lsu_op_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic lsu_size_t size_of(lsu_op_t op);
        lsu_size_t sz;
        case (op)
            LB, LBU, SB: sz = SZ_BYTE;
            LH, LHU, SH: sz = SZ_HALF;
            default:     sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian byte-lane steering: extracts and extends load data from a RAM word,
// and merges right-justified store data into the selected lanes of that word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_word,
    output logic [31:0] merge_word
);

    lsu_op_t   op_t;
    lsu_size_t size;
    logic [7:0]  lane [4];
    logic [7:0]  merged_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign op_t = lsu_op_t'(op);
    assign size = size_of(op_t);

    // Lane 0 is the most significant byte of the word (big-endian).
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        logic       hit;
        logic [7:0] st_byte;

        assign lane[gi] = mem_word[31-8*gi -: 8];
        assign hit = (size == SZ_WORD)
                  || (size == SZ_HALF && offset[1] == LANE[1])
                  || (size == SZ_BYTE && offset == LANE);
        assign st_byte = (size == SZ_WORD) ? store_data[31-8*gi -: 8] :
                         (size == SZ_HALF && !LANE[0]) ? store_data[15:8] :
                         store_data[7:0];
        assign merged_lane[gi] = hit ? st_byte : lane[gi];
    end

    assign merge_word = {merged_lane[0], merged_lane[1], merged_lane[2], merged_lane[3]};
    assign byte_sel   = lane[offset];
    assign half_sel   = offset[1] ? mem_word[15:0] : mem_word[31:16];

    always_comb begin
        load_word = 32'd0;
        case (op_t)
            LB:      load_word = {{24{byte_sel[7]}}, byte_sel};
            LBU:     load_word = {24'd0, byte_sel};
            LH:      load_word = {{16{half_sel[15]}}, half_sel};
            LHU:     load_word = {16'd0, half_sel};
            LW:      load_word = mem_word;
            default: load_word = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator between the core memory stage and a word-wide big-endian
// RAM with one-cycle registered read; sub-word stores become read-modify-write.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    lsu_state_t state;
    lsu_op_t    op_reg;
    logic [1:0] off_reg;
    logic [31:0] wdata_reg;

    lsu_op_t   req_op_t;
    lsu_size_t req_size;
    logic      req_misaligned;
    logic      req_out_of_range;
    logic      req_err;
    logic [ADDR_W-1:0] req_word_addr;
    logic [31:0] load_word;
    logic [31:0] merge_word;

    assign req_op_t         = lsu_op_t'(req_op);
    assign req_size         = size_of(req_op_t);
    assign req_misaligned   = ((req_size == SZ_HALF) && req_addr[0])
                           || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign req_out_of_range = (req_addr >= ADDR_W'(MEM_BYTES));
    assign req_err          = req_misaligned || req_out_of_range;
    assign req_word_addr    = {req_addr[ADDR_W-1:2], 2'b00};

    assign req_ready = (state == ST_IDLE) && rst_n;

    lsu_lane_align u_align (
        .op         (op_reg),
        .offset     (off_reg),
        .mem_word   (mem_rd),
        .store_data (wdata_reg),
        .load_word  (load_word),
        .merge_word (merge_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_reg     <= LB;
            off_reg    <= 2'b00;
            wdata_reg  <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            mem_a      <= '0;
            mem_we     <= 1'b0;
            mem_wd     <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                    mem_a      <= '0;
                    mem_we     <= 1'b0;
                    mem_wd     <= 32'd0;
                    if (req_valid) begin
                        op_reg    <= req_op_t;
                        off_reg   <= req_addr[1:0];
                        wdata_reg <= req_wdata;
                        if (req_err) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_op_t == SW) begin
                            state  <= ST_WRITE;
                            mem_a  <= req_word_addr;
                            mem_we <= 1'b1;
                            mem_wd <= req_wdata;
                        end else begin
                            state <= ST_RD_ISSUE;
                            mem_a <= req_word_addr;
                        end
                    end
                end
                ST_RD_ISSUE: begin
                    state <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    // mem_rd now holds the word addressed during RD_ISSUE.
                    if (is_store(op_reg)) begin
                        state  <= ST_WRITE;
                        mem_we <= 1'b1;
                        mem_wd <= merge_word;
                    end else begin
                        state      <= ST_RESP;
                        mem_a      <= '0;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_word;
                    end
                end
                ST_WRITE: begin
                    state      <= ST_RESP;
                    mem_a      <= '0;
                    mem_we     <= 1'b0;
                    mem_wd     <= 32'd0;
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                end
                ST_RESP: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomized self-checking bench for lsu_mem_port against a byte-array memory model.
module tb_lsu_mem_port;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd = 32'd0;

    logic [31:0] ram  [0:1023];
    logic [7:0]  gold [0:4095];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_mem_port #(.MEM_BYTES(4096), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_a      (mem_a),
        .mem_we     (mem_we),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always @(posedge clk) begin
        if (mem_we) ram[mem_a[11:2]] <= mem_wd;
        mem_rd <= ram[mem_a[11:2]];
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic model_err(lsu_op_t op, logic [31:0] a);
        return (a >= 32'd4096)
            || ((op == LH || op == LHU || op == SH) && a[0])
            || ((op == LW || op == SW) && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] gold_word(logic [31:0] a);
        int b;
        b = int'(a & 32'hFFC);
        return {gold[b], gold[b+1], gold[b+2], gold[b+3]};
    endfunction

    function automatic logic [31:0] model_load(lsu_op_t op, logic [31:0] a);
        int b;
        logic [31:0] v;
        b = int'(a);
        case (op)
            LB:  v = {{24{gold[b][7]}}, gold[b]};
            LBU: v = {24'd0, gold[b]};
            LH:  v = {{16{gold[b][7]}}, gold[b], gold[b+1]};
            LHU: v = {16'd0, gold[b], gold[b+1]};
            LW:  v = {gold[b], gold[b+1], gold[b+2], gold[b+3]};
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    task automatic model_store(lsu_op_t op, logic [31:0] a, logic [31:0] wd);
        int b;
        b = int'(a);
        case (op)
            SB: gold[b] = wd[7:0];
            SH: begin gold[b] = wd[15:8]; gold[b+1] = wd[7:0]; end
            SW: begin
                gold[b] = wd[31:24]; gold[b+1] = wd[23:16];
                gold[b+2] = wd[15:8]; gold[b+3] = wd[7:0];
            end
            default: ;
        endcase
    endtask

    task automatic do_req(input lsu_op_t op, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd_out);
        logic        e_err;
        logic [31:0] e_rd;
        logic [31:0] e_word;
        int          e_lat;
        int          lat;
        int          wes;
        int          w;
        logic [31:0] got_rd;
        logic        got_err;

        e_err  = model_err(op, a);
        e_rd   = (e_err || is_store(op)) ? 32'd0 : model_load(op, a);
        e_lat  = e_err ? 1 : (op == SW) ? 2 : is_store(op) ? 4 : 3;
        if (!e_err && is_store(op)) model_store(op, a, wd);
        e_word = (a < 32'd4096) ? gold_word(a) : 32'd0;

        @(negedge clk);
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;

        lat = 0; wes = 0; got_rd = 32'hX; got_err = 1'bX;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (mem_we) begin
                wes++;
                check("mem_wd", mem_wd, e_word);
                check("mem_a", mem_a, a & 32'hFFFF_FFFC);
            end
            if (resp_valid) begin
                lat = c;
                got_rd = resp_rdata;
                got_err = resp_err;
                break;
            end
        end
        check("latency", 32'(lat), 32'(e_lat));
        check("resp_err", {31'd0, got_err}, {31'd0, e_err});
        check("resp_rdata", got_rd, e_rd);
        check("we_count", 32'(wes), (!e_err && is_store(op)) ? 32'd1 : 32'd0);
        if (a < 32'd4096) check("ram_word", ram[a[11:2]], e_word);
        @(posedge clk);
        #1;
        check("resp_pulse", {31'd0, resp_valid}, 32'd0);
        check("idle_mem_a", mem_a, 32'd0);
        $display("txn op=%s addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
                 op.name(), a, wd, got_rd, got_err, lat);
        rd_out = got_rd;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] w;
        int wes;
        lsu_op_t op;
        logic [31:0] a;

        for (int i = 0; i < 1024; i++) begin
            w = (i == 32'h40) ? 32'h8123_45F6 : $urandom;
            ram[i] = w;
            gold[4*i] = w[31:24]; gold[4*i+1] = w[23:16];
            gold[4*i+2] = w[15:8]; gold[4*i+3] = w[7:0];
        end

        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        do_req(LB,  32'h100, 32'd0, rd); check("tp_lb100", rd, 32'hFFFF_FF81);
        do_req(LB,  32'h101, 32'd0, rd); check("tp_lb101", rd, 32'h0000_0023);
        do_req(LB,  32'h103, 32'd0, rd); check("tp_lb103", rd, 32'hFFFF_FFF6);
        do_req(LBU, 32'h100, 32'd0, rd); check("tp_lbu100", rd, 32'h0000_0081);
        do_req(LH,  32'h102, 32'd0, rd); check("tp_lh102", rd, 32'h0000_45F6);
        do_req(LH,  32'h100, 32'd0, rd); check("tp_lh100", rd, 32'hFFFF_8123);
        do_req(LHU, 32'h100, 32'd0, rd); check("tp_lhu100", rd, 32'h0000_8123);
        do_req(LW,  32'h100, 32'd0, rd); check("tp_lw100", rd, 32'h8123_45F6);
        do_req(SB,  32'h101, 32'h0000_00AA, rd); check("tp_sb_word", ram[32'h40], 32'h81AA_45F6);
        do_req(SH,  32'h102, 32'h0000_BEEF, rd); check("tp_sh_word", ram[32'h40], 32'h81AA_BEEF);
        do_req(SW,  32'h200, 32'hDEAD_BEEF, rd);
        do_req(LW,  32'h200, 32'd0, rd); check("tp_lw200", rd, 32'hDEAD_BEEF);
        do_req(LW,  32'h102, 32'd0, rd);
        do_req(SH,  32'h103, 32'h0000_1234, rd);
        do_req(LB,  32'h1000, 32'd0, rd);
        check("tp_err_ram", ram[32'h40], 32'h81AA_BEEF);

        // Reset arriving while a sub-word store sits in RD_CAP.
        @(negedge clk);
        req_valid = 1'b1; req_op = SB; req_addr = 32'h101; req_wdata = 32'h55;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        wes = 0;
        check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        check("mid_rst_mem_a", mem_a, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            if (mem_we) wes++;
        end
        check("mid_rst_we", 32'(wes), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        check("post_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("post_rst_word", ram[32'h40], 32'h81AA_BEEF);
        do_req(LW, 32'h100, 32'd0, rd); check("post_rst_lw", rd, 32'h81AA_BEEF);

        for (int n = 0; n < 300; n++) begin
            op = lsu_op_t'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       a = 32'd4096 + $urandom_range(0, 5000);
                1:       a = 32'hFFFF_FFFC;
                default: a = $urandom_range(32'h100, 32'h17F);
            endcase
            do_req(op, a, $urandom, rd);
        end

        for (int i = 0; i < 1024; i++) begin
            if (ram[i] !== gold_word(32'(4*i))) check("final_ram", ram[i], gold_word(32'(4*i)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
